// File: rtl/wave_sequencer.sv
// Step sequencer that replays an 8-entry {mask, length} pattern into the waveform mixer's enables and gate.
// Optional looping at pattern end is built only when WAVE_SEQ_LOOP_EN is defined.
module wave_sequencer #(
    parameter int TICK_DIV  = 1000,
    parameter int GAP_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_mask,
    input  logic [7:0] wr_len,
    output logic [3:0] wave_en,
    output logic       gate,
    output logic [2:0] step,
    output logic       busy,
    output logic       done
);

    localparam int               DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam bit               HAS_GAP  = (GAP_TICKS > 0);
    localparam logic [7:0]       GAP_LAST = HAS_GAP ? 8'(GAP_TICKS - 1) : 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           r_state;
    logic [3:0]       r_pat_mask [8];
    logic [7:0]       r_pat_len  [8];
    logic [DIV_W-1:0] r_div_cnt;
    logic [7:0]       r_tick_cnt;
    logic [3:0]       r_wave_en;
    logic             r_gate;
    logic [2:0]       r_step;
    logic             r_busy;
    logic             r_done;

    logic             w_tick;
    logic [2:0]       w_next_step;
    logic [2:0]       w_dec_step;
    logic             w_at_end;
    logic             w_restart;
    logic             w_play_end;
    logic             w_gap_end;
    logic             w_decide;
    logic             w_wr_ok;

`ifdef WAVE_SEQ_LOOP_EN
    assign w_restart = w_at_end && loop;
`else
    logic w_loop_unused;
    assign w_loop_unused = loop;
    assign w_restart     = 1'b0;
`endif

    // Step-boundary and next-step decision terms derived from the current counters
    always_comb begin
        w_tick      = (r_div_cnt == DIV_LAST);
        w_next_step = r_step + 3'd1;
        w_at_end    = (r_step == 3'd7) || (r_pat_len[w_next_step] == 8'd0);
        w_dec_step  = w_at_end ? 3'd0 : w_next_step;
        w_play_end  = (r_state == ST_PLAY) && w_tick &&
                      (r_tick_cnt == (r_pat_len[r_step] - 8'd1));
        w_gap_end   = (r_state == ST_GAP) && w_tick && (r_tick_cnt == GAP_LAST);
        w_decide    = w_gap_end || (w_play_end && !HAS_GAP);
        w_wr_ok     = wr_en && (r_state == ST_IDLE);
    end

    // Pattern storage; the pattern is frozen while playback is running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_pat_mask[i] <= 4'd0;
                r_pat_len[i]  <= 8'd0;
            end
        end else if (w_wr_ok) begin
            r_pat_mask[wr_addr] <= wr_mask;
            r_pat_len[wr_addr]  <= wr_len;
        end
    end

    // Playback FSM with tick prescaler and registered mixer controls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_div_cnt  <= '0;
            r_tick_cnt <= 8'd0;
            r_wave_en  <= 4'd0;
            r_gate     <= 1'b0;
            r_step     <= 3'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (stop) begin
                r_state    <= ST_IDLE;
                r_div_cnt  <= '0;
                r_tick_cnt <= 8'd0;
                r_wave_en  <= 4'd0;
                r_gate     <= 1'b0;
                r_step     <= 3'd0;
                r_busy     <= 1'b0;
            end else if (w_decide) begin
                // Counters restart on every state entry so each step length is exact
                r_div_cnt  <= '0;
                r_tick_cnt <= 8'd0;
                if (!w_at_end || w_restart) begin
                    r_state   <= ST_PLAY;
                    r_step    <= w_dec_step;
                    r_wave_en <= r_pat_mask[w_dec_step];
                    r_gate    <= 1'b1;
                    r_busy    <= 1'b1;
                end else begin
                    r_state   <= ST_IDLE;
                    r_step    <= 3'd0;
                    r_wave_en <= 4'd0;
                    r_gate    <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_div_cnt  <= '0;
                        r_tick_cnt <= 8'd0;
                        if (start) begin
                            if (r_pat_len[0] != 8'd0) begin
                                r_state   <= ST_PLAY;
                                r_step    <= 3'd0;
                                r_wave_en <= r_pat_mask[0];
                                r_gate    <= 1'b1;
                                r_busy    <= 1'b1;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    ST_PLAY: begin
                        if (w_play_end) begin
                            r_state    <= ST_GAP;
                            r_gate     <= 1'b0;
                            r_div_cnt  <= '0;
                            r_tick_cnt <= 8'd0;
                        end else if (w_tick) begin
                            r_div_cnt  <= '0;
                            r_tick_cnt <= r_tick_cnt + 8'd1;
                        end else begin
                            r_div_cnt <= r_div_cnt + DIV_W'(1);
                        end
                    end
                    ST_GAP: begin
                        if (w_tick) begin
                            r_div_cnt  <= '0;
                            r_tick_cnt <= r_tick_cnt + 8'd1;
                        end else begin
                            r_div_cnt <= r_div_cnt + DIV_W'(1);
                        end
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_div_cnt  <= '0;
                        r_tick_cnt <= 8'd0;
                        r_wave_en  <= 4'd0;
                        r_gate     <= 1'b0;
                        r_step     <= 3'd0;
                        r_busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign wave_en = r_wave_en;
    assign gate    = r_gate;
    assign step    = r_step;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed bench for wave_sequencer with TICK_DIV=4, GAP_TICKS=1; outputs are checked as one packed
// {busy, gate, wave_en, step, done} vector per cycle.
module tb_wave_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       loop;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_mask;
    logic [7:0] wr_len;
    logic [3:0] wave_en;
    logic       gate;
    logic [2:0] step;
    logic       busy;
    logic       done;

    int n_total;
    int n_bad;

    wave_sequencer #(
        .TICK_DIV  (4),
        .GAP_TICKS (1)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .loop    (loop),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_mask (wr_mask),
        .wr_len  (wr_len),
        .wave_en (wave_en),
        .gate    (gate),
        .step    (step),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [9:0] obs_vec();
        return {busy, gate, wave_en, step, done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_step(input logic [2:0] a, input logic [3:0] m, input logic [7:0] l);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_mask = m;
        wr_len  = l;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic start_play();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // n cycles of a busy segment with the given gate, mask and step
    task automatic seg(input string tag, input logic g, input int n, input logic [3:0] m, input logic [2:0] s);
        logic [9:0] e;
        e = {1'b1, g, m, s, 1'b0};
        for (int i = 0; i < n; i++) begin
            check_val(tag, 32'(obs_vec()), 32'(e));
            tick();
        end
    endtask

    // done cycle (first IDLE cycle) followed by a quiet IDLE cycle
    task automatic fin(input string tag);
        check_val({tag, "_done"}, 32'(obs_vec()), 32'h001);
        tick();
        check_val({tag, "_after"}, 32'(obs_vec()), 32'h000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        loop    = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 3'd0;
        wr_mask = 4'd0;
        wr_len  = 8'd0;
        tick();
        tick();
        check_val("reset_hold", 32'(obs_vec()), 32'h000);
        rst_n = 1'b1;
        tick();
        check_val("reset_rel", 32'(obs_vec()), 32'h000);

        // all-zero pattern: a lone done pulse, gate never rises
        start_play();
        fin("zero_pat");

        // single step {1000, 3}
        write_step(3'd0, 4'b1000, 8'd3);
        write_step(3'd1, 4'b0000, 8'd0);
        start_play();
        seg("one_play", 1'b1, 12, 4'b1000, 3'd0);
        seg("one_gap",  1'b0, 4,  4'b1000, 3'd0);
        fin("one");

        // three steps
        write_step(3'd0, 4'b1000, 8'd2);
        write_step(3'd1, 4'b0100, 8'd1);
        write_step(3'd2, 4'b0011, 8'd3);
        write_step(3'd3, 4'b0000, 8'd0);
        start_play();
        seg("three_p0", 1'b1, 8,  4'b1000, 3'd0);
        seg("three_g0", 1'b0, 4,  4'b1000, 3'd0);
        seg("three_p1", 1'b1, 4,  4'b0100, 3'd1);
        seg("three_g1", 1'b0, 4,  4'b0100, 3'd1);
        seg("three_p2", 1'b1, 12, 4'b0011, 3'd2);
        seg("three_g2", 1'b0, 4,  4'b0011, 3'd2);
        fin("three");

        // loop over a two-step pattern
        write_step(3'd0, 4'b0001, 8'd1);
        write_step(3'd1, 4'b0010, 8'd1);
        write_step(3'd2, 4'b0000, 8'd0);
        loop = 1'b1;
        start_play();
        seg("loop_p0", 1'b1, 4, 4'b0001, 3'd0);
        seg("loop_g0", 1'b0, 4, 4'b0001, 3'd0);
        seg("loop_p1", 1'b1, 4, 4'b0010, 3'd1);
        seg("loop_g1", 1'b0, 4, 4'b0010, 3'd1);
`ifdef WAVE_SEQ_LOOP_EN
        seg("loop_r0", 1'b1, 4, 4'b0001, 3'd0);
        seg("loop_rg0", 1'b0, 4, 4'b0001, 3'd0);
        loop = 1'b0;
        seg("loop_r1", 1'b1, 4, 4'b0010, 3'd1);
        seg("loop_rg1", 1'b0, 4, 4'b0010, 3'd1);
`endif
        fin("loop");
        loop = 1'b0;

        // stop in GAP with start held in the same cycle
        start_play();
        seg("stop_p0", 1'b1, 4, 4'b0001, 3'd0);
        seg("stop_g0", 1'b0, 1, 4'b0001, 3'd0);
        stop  = 1'b1;
        start = 1'b1;
        tick();
        check_val("stop_idle", 32'(obs_vec()), 32'h000);
        stop  = 1'b0;
        start = 1'b0;
        tick();
        check_val("stop_nodone", 32'(obs_vec()), 32'h000);

        // write while busy must not extend the pattern
        start_play();
        wr_en   = 1'b1;
        wr_addr = 3'd2;
        wr_mask = 4'b1111;
        wr_len  = 8'd5;
        seg("bw_p0a", 1'b1, 1, 4'b0001, 3'd0);
        wr_en   = 1'b0;
        seg("bw_p0b", 1'b1, 3, 4'b0001, 3'd0);
        seg("bw_g0",  1'b0, 4, 4'b0001, 3'd0);
        seg("bw_p1",  1'b1, 4, 4'b0010, 3'd1);
        seg("bw_g1",  1'b0, 4, 4'b0010, 3'd1);
        fin("bw");

        // all eight steps, ends after step 7
        for (int k = 0; k < 8; k++) write_step(3'(k), 4'(k + 1), 8'd1);
        start_play();
        for (int k = 0; k < 8; k++) begin
            seg("wrap_p", 1'b1, 4, 4'(k + 1), 3'(k));
            seg("wrap_g", 1'b0, 4, 4'(k + 1), 3'(k));
        end
        fin("wrap");

        // asynchronous reset mid-PLAY
        start_play();
        seg("rst_p0", 1'b1, 2, 4'b0001, 3'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_async", 32'(obs_vec()), 32'h000);
        #1;
        rst_n = 1'b1;
        tick();
        check_val("rst_idle", 32'(obs_vec()), 32'h000);
        start_play();
        fin("rst_zero");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/wave_sequencer.md
# wave_sequencer

Step sequencer that drives the waveform-mixer controls of the synthesiser: the per-waveform enable mask (square, saw, tri, sine) and the gate that the mixer treats as its button input. It replays a small programmed pattern of steps. Each step is a waveform mask plus a duration. The block sits between the user-control logic (switches, buttons, or a host write port) and the signal adder, replacing direct switch/button wiring during playback. Clock is the 1 MHz system clock.

## Interface
- TICK_DIV, 1000: clk cycles per duration tick (1 ms at 1 MHz); must be ≥ 2
- GAP_TICKS, 2: ticks of gate-low silence between steps; 0 means no gap
- clk  in  1  1 MHz system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level-sampled; begins playback from step 0 when idle
- stop  in  1  aborts playback; has priority over start
- loop  in  1  at pattern end, restart from step 0 instead of finishing
- wr_en  in  1  pattern write strobe
- wr_addr  in  3  step index 0..7
- wr_mask  in  4  waveform mask; bit3 square, bit2 saw, bit1 tri, bit0 sine
- wr_len  in  8  step duration in ticks; 0 marks end of pattern
- wave_en  out  4  mask to the mixer's waveform selects
- gate  out  1  mixer gate; high means sound
- step  out  3  index of the current step
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse when playback finishes normally

## Operation
- Pattern storage is 8 entries of {mask[3:0], len[7:0]}, held in registers.
- Writes are accepted only in IDLE. Writes while busy are ignored.
- States:
  - IDLE: gate=0, wave_en=0.
  - PLAY: gate=1, wave_en=mask[step].
  - GAP: gate=0, wave_en holds mask[step].
- IDLE→PLAY: start=1, stop=0, and len[0]≠0. step=0.
  - start in IDLE with len[0]=0: stay IDLE and pulse done.
- PLAY→GAP: after len[step] ticks, if GAP_TICKS>0. Otherwise go directly to the next-step decision.
- GAP→next-step decision: after GAP_TICKS ticks.
- Next-step decision:
  - End of pattern: step=7, or len[step+1]=0.
  - Not at end: go to PLAY with step+1.
  - At end with loop=1: go to PLAY with step=0.
  - At end with loop=0: go to IDLE and pulse done.
- loop is sampled only at the decision point.
- stop=1 in any state: IDLE on the next edge. gate=0, wave_en=0, step=0, no done pulse.
- start while busy is ignored.
- Tick prescaler: a 0..TICK_DIV-1 counter cleared on every state entry, so durations are exact. The tick counter is 8 bits.
- Reset: all outputs 0, all pattern entries 0, state IDLE, counters 0. Reset mid-playback behaves like stop but is immediate (asynchronous).

## Timing
- All outputs are registered.
- start sampled high at edge E0: gate, busy, and wave_en are valid after E0.
- gate is high for exactly len[k]·TICK_DIV cycles, then low for exactly GAP_TICKS·TICK_DIV cycles.
- With GAP_TICKS=0, consecutive steps are back-to-back. Gate stays high and only wave_en/step change.
- done is high for exactly one cycle. That cycle is the first IDLE cycle, with busy=0 and gate=0 in the same cycle.
- For start with len[0]=0, done occurs the cycle after E0.
- stop sampled at edge E: outputs are idle after E.
- A write sampled in IDLE at edge E is visible to a start sampled at E+1.

## Configuration
- WAVE_SEQ_LOOP_EN defined: loop input behaves as above.
- WAVE_SEQ_LOOP_EN undefined:
  - loop is ignored and no loop logic is built.
  - Every pattern end goes to IDLE with done.

## Test plan
All scenarios use TICK_DIV=4 and GAP_TICKS=1.

- Reset: assert rst_n=0 mid-PLAY → outputs go 0 immediately, without waiting for a clock edge. After release, start with an all-zero pattern gives a single done pulse and gate stays 0.
- Single step: write step0 {4'b1000, 3}, step1 len 0, then start → gate high 12 cycles, wave_en=1000, then gap 4 cycles, then done one cycle with busy=0.
- Three steps: steps {1000,2}, {0100,1}, {0011,3}, then start → gate highs of 8, 4, and 12 cycles, each separated by 4 low cycles. wave_en sequence is 1000, 0100, 0011 and step sequence is 0, 1, 2. Then done.
- Loop (macro defined): two-step pattern with loop=1 → after the step1 gap, step=0 and wave_en=mask0. Deassert loop during step1 → playback finishes with done at the next end. With the macro undefined, the same stimulus gives done after the first pass.
- Stop: stop during a GAP state, with start held high in the same cycle → IDLE next cycle, gate=0, wave_en=0, no done. A write with wr_en issued while busy leaves the pattern unchanged (confirm by reading back via playback).
- Step 7 wrap: all 8 entries non-zero with loop=0 → playback ends after step 7 with done. step never exceeds 7.
